// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 8-bit snooping bus.
// Grants one requester at a time; ReadMiss holds the bus until memory answers.
module snoop_bus_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter logic [1:0]  Idle      = 2'b00,
  parameter logic [1:0]  ReadMiss  = 2'b01,
  parameter logic [1:0]  WriteBack = 2'b10,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   msg_in,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             bus,
  output logic                   bus_valid,
  input  logic [3:0]             mem_q,
  output logic                   resp_valid,
  output logic [3:0]             resp_data,
  output logic [1:0]             resp_id
);

  localparam int unsigned CW        = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [7:0]  IDLE_WORD = {Idle, 6'b0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [1:0]           owner_q, owner_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [7:0]           bus_q, bus_d;
  logic                 bus_valid_q, bus_valid_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [3:0]           resp_data_q, resp_data_d;
  logic [1:0]           resp_id_q, resp_id_d;

  logic                 found;
  logic [1:0]           win;
  logic [2:0]           idx;

  // Rotating priority scan: first set req bit starting at ptr, wrapping mod NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr_q} + 3'(i);
      if (idx >= 3'(NUM_REQ)) idx = idx - 3'(NUM_REQ);
      if (!found && req[idx[1:0]]) begin
        found = 1'b1;
        win   = idx[1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    bus_d        = bus_q;
    bus_valid_d  = bus_valid_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_DRIVE;
          grant_d[win] = 1'b1;
          bus_d        = msg_in[{win, 3'b000} +: 8];
          bus_valid_d  = 1'b1;
          owner_d      = win;
          ptr_d        = (win == 2'(NUM_REQ - 1)) ? 2'd0 : win + 2'd1;
        end else begin
          bus_d       = IDLE_WORD;
          bus_valid_d = 1'b0;
        end
      end
      S_DRIVE: begin
        unique case (bus_q[7:6])
          ReadMiss: begin
            state_d = S_WAIT;
            cnt_d   = CW'(MEM_LAT - 1);
          end
          WriteBack: begin
            state_d     = S_IDLE;
            bus_d       = IDLE_WORD;
            bus_valid_d = 1'b0;
          end
          default: begin
            state_d     = S_IDLE;
            bus_d       = IDLE_WORD;
            bus_valid_d = 1'b0;
          end
        endcase
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = mem_q;
          resp_id_d    = owner_q;
          bus_d        = IDLE_WORD;
          bus_valid_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      bus_q        <= '0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      bus_q        <= bus_d;
      bus_valid_q  <= bus_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign grant      = grant_q;
  assign bus        = bus_q;
  assign bus_valid  = bus_valid_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: one instance with MEM_LAT=1, one with MEM_LAT=3.
module tb_snoop_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic [2:0]  req = '0;
  logic [23:0] msg_in = '0;
  logic [2:0]  grant;
  logic [7:0]  bus;
  logic        bus_valid;
  logic [3:0]  mem_q;
  logic        resp_valid;
  logic [3:0]  resp_data;
  logic [1:0]  resp_id;

  logic [2:0]  req3 = '0;
  logic [23:0] msg_in3 = '0;
  logic [2:0]  grant3;
  logic [7:0]  bus3;
  logic        bus_valid3;
  logic [3:0]  mem_q3;
  logic        resp_valid3;
  logic [3:0]  resp_data3;
  logic [1:0]  resp_id3;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  // Memory contents per block tag, answered combinationally from the bus word.
  function automatic logic [3:0] mem_model(input logic [1:0] tag);
    case (tag)
      2'd0:    return 4'h5;
      2'd1:    return 4'h9;
      2'd2:    return 4'hC;
      default: return 4'hB;
    endcase
  endfunction

  assign mem_q  = mem_model(bus[5:4]);
  assign mem_q3 = mem_model(bus3[5:4]);

  snoop_bus_arbiter #(.NUM_REQ(3), .MEM_LAT(1)) dut (
    .clock(clock), .reset(reset), .req(req), .msg_in(msg_in),
    .grant(grant), .bus(bus), .bus_valid(bus_valid), .mem_q(mem_q),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_id(resp_id)
  );

  snoop_bus_arbiter #(.NUM_REQ(3), .MEM_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .req(req3), .msg_in(msg_in3),
    .grant(grant3), .bus(bus3), .bus_valid(bus_valid3), .mem_q(mem_q3),
    .resp_valid(resp_valid3), .resp_data(resp_data3), .resp_id(resp_id3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Observed vectors below are {grant, bus, bus_valid, resp_valid}.
  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    req3  = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({grant, bus, bus_valid, resp_valid} !== {3'b000, 8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle[%0d]: got %h want %h", i, {grant, bus, bus_valid, resp_valid}, 13'h0);
      end
      checks++;
      if ({grant3, bus3, bus_valid3, resp_valid3} !== {3'b000, 8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle3[%0d]: got %h want %h", i, {grant3, bus3, bus_valid3, resp_valid3}, 13'h0);
      end
    end
    checks++;
    if ({resp_data, resp_id} !== 6'h00) begin
      errors++;
      $display("FAIL reset_resp_regs: got %h want %h", {resp_data, resp_id}, 6'h00);
    end
  endtask

  task automatic test_writeback();
    req          = 3'b001;
    msg_in[7:0]  = 8'hA6;
    tick();
    req = '0;
    checks++;
    if ({grant, bus, bus_valid, resp_valid} !== {3'b001, 8'hA6, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wb_drive: got %h want %h", {grant, bus, bus_valid, resp_valid}, {3'b001, 8'hA6, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if ({grant, bus, bus_valid, resp_valid} !== {3'b000, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wb_release: got %h want %h", {grant, bus, bus_valid, resp_valid}, 13'h0);
    end
    tick();
    checks++;
    if ({grant, bus, bus_valid, resp_valid} !== {3'b000, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL wb_no_resp: got %h want %h", {grant, bus, bus_valid, resp_valid}, 13'h0);
    end
  endtask

  task automatic test_readmiss();
    req           = 3'b100;
    msg_in[23:16] = 8'h70;
    tick();
    req = '0;
    checks++;
    if ({grant, bus, bus_valid, resp_valid} !== {3'b100, 8'h70, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rm_drive: got %h want %h", {grant, bus, bus_valid, resp_valid}, {3'b100, 8'h70, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if ({grant, bus, bus_valid, resp_valid} !== {3'b000, 8'h70, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rm_wait: got %h want %h", {grant, bus, bus_valid, resp_valid}, {3'b000, 8'h70, 1'b1, 1'b0});
    end
    tick();
    checks++;
    if ({grant, bus, bus_valid, resp_valid, resp_data, resp_id} !== {3'b000, 8'h00, 1'b0, 1'b1, 4'hB, 2'd2}) begin
      errors++;
      $display("FAIL rm_resp: got %h want %h", {grant, bus, bus_valid, resp_valid, resp_data, resp_id},
               {3'b000, 8'h00, 1'b0, 1'b1, 4'hB, 2'd2});
    end
    tick();
    checks++;
    if ({resp_valid, resp_data} !== {1'b0, 4'hB}) begin
      errors++;
      $display("FAIL rm_after: got %h want %h", {resp_valid, resp_data}, {1'b0, 4'hB});
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    logic [7:0] exp_b [4];
    exp_g[0] = 3'b001; exp_b[0] = 8'h81;
    exp_g[1] = 3'b010; exp_b[1] = 8'h92;
    exp_g[2] = 3'b100; exp_b[2] = 8'hA3;
    exp_g[3] = 3'b001; exp_b[3] = 8'h81;
    msg_in = {8'hA3, 8'h92, 8'h81};
    req    = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({grant, bus, bus_valid} !== {exp_g[i], exp_b[i], 1'b1}) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %h want %h", i, {grant, bus, bus_valid}, {exp_g[i], exp_b[i], 1'b1});
      end
      if (i == 3) req = '0;
      tick();
      checks++;
      if ({grant, bus_valid} !== 4'b0000) begin
        errors++;
        $display("FAIL rr_gap[%0d]: got %h want %h", i, {grant, bus_valid}, 4'b0000);
      end
    end
  endtask

  task automatic test_contention();
    req3         = 3'b001;
    msg_in3[7:0] = 8'h50;
    tick();
    req3 = '0;
    checks++;
    if ({grant3, bus3, bus_valid3} !== {3'b001, 8'h50, 1'b1}) begin
      errors++;
      $display("FAIL ct_drive: got %h want %h", {grant3, bus3, bus_valid3}, {3'b001, 8'h50, 1'b1});
    end
    tick();
    req3          = 3'b010;
    msg_in3[15:8] = 8'h8F;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({grant3, bus3, bus_valid3, resp_valid3} !== {3'b000, 8'h50, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL ct_wait[%0d]: got %h want %h", i, {grant3, bus3, bus_valid3, resp_valid3},
                 {3'b000, 8'h50, 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({grant3, bus3, bus_valid3, resp_valid3, resp_data3, resp_id3} !== {3'b000, 8'h00, 1'b0, 1'b1, 4'h9, 2'd0}) begin
      errors++;
      $display("FAIL ct_resp: got %h want %h", {grant3, bus3, bus_valid3, resp_valid3, resp_data3, resp_id3},
               {3'b000, 8'h00, 1'b0, 1'b1, 4'h9, 2'd0});
    end
    tick();
    checks++;
    if ({grant3, bus_valid3, resp_valid3} !== 5'b00000) begin
      errors++;
      $display("FAIL ct_idle: got %h want %h", {grant3, bus_valid3, resp_valid3}, 5'b00000);
    end
    tick();
    req3 = '0;
    checks++;
    if ({grant3, bus3, bus_valid3} !== {3'b010, 8'h8F, 1'b1}) begin
      errors++;
      $display("FAIL ct_next_grant: got %h want %h", {grant3, bus3, bus_valid3}, {3'b010, 8'h8F, 1'b1});
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    req3         = 3'b001;
    msg_in3[7:0] = 8'h60;
    tick();
    req3 = '0;
    checks++;
    if (grant3 !== 3'b001) begin
      errors++;
      $display("FAIL rmw_grant: got %b want %b", grant3, 3'b001);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({grant3, bus3, bus_valid3, resp_valid3, resp_data3, resp_id3} !== 19'h0) begin
      errors++;
      $display("FAIL rmw_reset: got %h want %h", {grant3, bus3, bus_valid3, resp_valid3, resp_data3, resp_id3}, 19'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({resp_valid3, bus_valid3} !== 2'b00) begin
        errors++;
        $display("FAIL rmw_quiet[%0d]: got %b want %b", i, {resp_valid3, bus_valid3}, 2'b00);
      end
    end
    msg_in3[7:0]  = 8'h81;
    msg_in3[15:8] = 8'h92;
    req3          = 3'b011;
    tick();
    req3 = '0;
    checks++;
    if ({grant3, bus3} !== {3'b001, 8'h81}) begin
      errors++;
      $display("FAIL rmw_ptr_zero: got %h want %h", {grant3, bus3}, {3'b001, 8'h81});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_readmiss();
    test_round_robin();
    test_contention();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
